multi_pad_controller: RTL

- Parametrised successor to the single-pad Genesis-style controller reader.
- Scans NUM_PADS pads in parallel, once per rising edge of vga_vs, using one shared 8-phase select sequence.
- Auto-detects per pad: absent, 3-button or 6-button.
- Publishes an atomic 12-bit button word per pad plus a pressed-edge vector, and sits between the pad pins and the game/robot control logic.

---
 rtl/multi_pad_controller_pkg.sv | 41 ++++
 rtl/pad_decode.sv | 85 ++++++++
 rtl/multi_pad_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/multi_pad_controller_pkg.sv
// Shared definitions for the multi-pad Genesis controller reader:
// button bit indices, sequencer states, sampling phases, pin bundle.
package multi_pad_controller_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;
  localparam int BTN_W     = 12;

  localparam logic [2:0] P_PRESENT = 3'd0;
  localparam logic [2:0] P_DIR     = 3'd1;
  localparam logic [2:0] P_SIX     = 3'd4;
  localparam logic [2:0] P_XYZ     = 3'd5;
  localparam logic [2:0] P_LAST    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  // Synchronised, still active-low pin levels of one pad.
  typedef struct packed {
    logic start_c;
    logic a_b;
    logic right;
    logic left_x;
    logic down_y;
    logic up_z;
  } pins_t;

endpackage

// File: rtl/pad_decode.sv
// Per-pad decoder: samples pins on phase strobes, tracks present/six
// flags and publishes the button word plus pressed edges.
//   in : clk, reset, sample, phase, publish, pins
//   out: buttons, edges, present, six
module pad_decode
  import multi_pad_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             sample,
  input  logic [2:0]       phase,
  input  logic             publish,
  input  pins_t            pins,
  output logic [BTN_W-1:0] buttons,
  output logic [BTN_W-1:0] edges,
  output logic             present,
  output logic             six
);

  logic [BTN_W-1:0] acc;
  logic [BTN_W-1:0] word_new;
  logic             pres_acc;
  logic             six_acc;

  always_comb begin
    word_new = '0;
    if (pres_acc) word_new = acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      pres_acc <= 1'b0;
      six_acc  <= 1'b0;
      buttons  <= '0;
      edges    <= '0;
      present  <= 1'b0;
      six      <= 1'b0;
    end else begin
      edges <= '0;
      if (sample) begin
        case (phase)
          P_PRESENT: begin
            pres_acc       <= ~pins.left_x & ~pins.right;
            acc            <= '0;
            acc[BTN_A]     <= ~pins.a_b;
            acc[BTN_START] <= ~pins.start_c;
          end
          P_DIR: begin
            acc[BTN_UP]    <= ~pins.up_z;
            acc[BTN_DOWN]  <= ~pins.down_y;
            acc[BTN_LEFT]  <= ~pins.left_x;
            acc[BTN_RIGHT] <= ~pins.right;
            acc[BTN_B]     <= ~pins.a_b;
            acc[BTN_C]     <= ~pins.start_c;
          end
          P_SIX: begin
            six_acc  <= pres_acc & ~pins.up_z & ~pins.down_y;
            // a live pad drives left/right low on every low select,
            // so losing that here means it was pulled mid-scan
            pres_acc <= pres_acc & ~pins.left_x & ~pins.right;
          end
          P_XYZ: begin
            if (six_acc) begin
              acc[BTN_MODE] <= ~pins.right;
              acc[BTN_Z]    <= ~pins.up_z;
              acc[BTN_Y]    <= ~pins.down_y;
              acc[BTN_X]    <= ~pins.left_x;
            end else begin
              acc[BTN_MODE:BTN_X] <= '0;
            end
          end
          default: ;
        endcase
      end
      if (publish) begin
        buttons <= word_new;
        edges   <= word_new & ~buttons;
        present <= pres_acc;
        six     <= six_acc & pres_acc;
      end
    end
  end

endmodule

// File: rtl/multi_pad_controller.sv
// Scans NUM_PADS Genesis pads per vga_vs frame with a shared select.
//   in : clk, reset(n), pad pins, vga_vs
//   out: selectSignal, buttonsOut, pressed_edge, pad_present, six_button, frame_valid
module multi_pad_controller
  import multi_pad_controller_pkg::*;
#(
  parameter int NUM_PADS     = 2,
  parameter int PHASE_CYCLES = 500,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PADS-1:0]       up_z,
  input  logic [NUM_PADS-1:0]       down_y,
  input  logic [NUM_PADS-1:0]       left_x,
  input  logic [NUM_PADS-1:0]       right,
  input  logic [NUM_PADS-1:0]       a_b,
  input  logic [NUM_PADS-1:0]       start_c,
  input  logic                      vga_vs,
  output logic [NUM_PADS-1:0]       selectSignal,
  output logic [BTN_W*NUM_PADS-1:0] buttonsOut,
  output logic [BTN_W*NUM_PADS-1:0] pressed_edge,
  output logic [NUM_PADS-1:0]       pad_present,
  output logic [NUM_PADS-1:0]       six_button,
  output logic                      frame_valid
);

  localparam int SW = 6 * NUM_PADS + 1;
  localparam int CW = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic [SW-1:0] raw;
  logic [SW-1:0] syn;
  logic          vs_s;
  logic          vs_d;
  logic          vs_rise;

  state_t        state;
  state_t        state_n;
  logic [2:0]    phase;
  logic [CW-1:0] cnt;
  logic          phase_end;
  logic          scan_done;
  logic          sel;

  assign raw = {vga_vs, start_c, a_b, right, left_x, down_y, up_z};
  assign syn = sync_q[SYNC_STAGES-1];
  assign vs_s = syn[SW-1];
  assign vs_rise = vs_s & ~vs_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      vs_d   <= 1'b0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      vs_d <= vs_s;
    end
  end

  assign phase_end = (state == ST_SCAN) && (cnt == CNT_LAST);
  assign scan_done = phase_end && (phase == P_LAST);

  always_comb begin
    state_n = state;
    unique case (1'b1)
      state == ST_IDLE:    if (vs_rise) state_n = ST_SCAN;
      state == ST_SCAN:    if (scan_done) state_n = ST_PUBLISH;
      state == ST_PUBLISH: state_n = ST_IDLE;
      default:             state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      phase <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == ST_SCAN) begin
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          // hold at the last phase; PUBLISH returns it to 0
          if (phase != P_LAST) phase <= phase + 3'd1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt   <= '0;
        phase <= '0;
      end
    end
  end

  assign sel = (state == ST_SCAN) ? phase[0] : 1'b1;
  assign selectSignal = {NUM_PADS{sel}};
  assign frame_valid = (state == ST_PUBLISH);

  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    pins_t pins;
    assign pins.up_z    = syn[k];
    assign pins.down_y  = syn[NUM_PADS + k];
    assign pins.left_x  = syn[2*NUM_PADS + k];
    assign pins.right   = syn[3*NUM_PADS + k];
    assign pins.a_b     = syn[4*NUM_PADS + k];
    assign pins.start_c = syn[5*NUM_PADS + k];

    pad_decode u_dec (
      .clk     (clk),
      .reset   (reset),
      .sample  (phase_end),
      .phase   (phase),
      .publish (scan_done),
      .pins    (pins),
      .buttons (buttonsOut[BTN_W*k +: BTN_W]),
      .edges   (pressed_edge[BTN_W*k +: BTN_W]),
      .present (pad_present[k]),
      .six     (six_button[k])
    );
  end

endmodule
